// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg
//   Shared definitions for the MUL/DIV control sequencer:
//   - state_t: sequencer states (IDLE, T0..T6, DONE)
//   - SRC_*  : bit positions in the one-hot bus-select vector
//   - EN_*   : bit positions in the one-hot register-enable vector
//   - OP_*   : ALU opcodes handled by this sequencer
//   - IR_*   : IR field positions (opcode, ra, rb)
//   - op_is_legal(): opcode legality check
// Configuration macro: MULDIV_SEQ_DIV_EN. When defined, DIV is a legal opcode.
// When undefined, only MUL is legal.
package muldiv_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  // Bus sources. R0..R15 use their register number as the bit index.
  localparam int SRC_HI  = 16;
  localparam int SRC_LO  = 17;
  localparam int SRC_ZHI = 18;
  localparam int SRC_ZLO = 19;
  localparam int SRC_PC  = 20;
  localparam int SRC_MDR = 21;

  // Register enables. R0..R15 use their register number as the bit index.
  localparam int EN_HI  = 16;
  localparam int EN_LO  = 17;
  localparam int EN_Z   = 18;
  localparam int EN_PC  = 20;
  localparam int EN_MDR = 21;
  localparam int EN_IR  = 22;
  localparam int EN_Y   = 23;
  localparam int EN_MAR = 25;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;

  function automatic logic op_is_legal(input logic [4:0] op);
`ifdef MULDIV_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/muldiv_seq_decode.sv
// muldiv_seq_decode
//   Combinational output decode for the MUL/DIV sequencer. Maps the current
//   state plus IR fields onto the datapath control vectors.
// Ports:
//   state      in   current sequencer state
//   opcode     in   IR opcode field
//   ra, rb     in   IR source register fields
//   legal      in   opcode is executable in this build
//   enable     out  one-hot register load enables
//   bus_select out  one-hot bus source select
//   mem_read   out  MDR loads from memory data
//   pc_inc     out  PC increment
//   alu_op     out  ALU opcode (driven only in T4)
//   busy       out  sequence in progress (T0..T6)
//   done       out  completion pulse (DONE state)
module muldiv_seq_decode
  import muldiv_seq_pkg::*;
#(
  parameter int ENABLE_W = 32,
  parameter int SELECT_W = 32,
  parameter int OPCODE_W = 5
) (
  input  logic                state_t_unused_guard,
  input  state_t              state,
  input  logic [4:0]          opcode,
  input  logic [3:0]          ra,
  input  logic [3:0]          rb,
  input  logic                legal,
  output logic [ENABLE_W-1:0] enable,
  output logic [SELECT_W-1:0] bus_select,
  output logic                mem_read,
  output logic                pc_inc,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                busy,
  output logic                done
);

  always_comb begin
    enable     = '0;
    bus_select = '0;
    mem_read   = 1'b0;
    pc_inc     = 1'b0;
    alu_op     = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_T0: begin
        // MAR is the only enable; PC advances through pc_inc, not EN_PC.
        busy               = 1'b1;
        bus_select[SRC_PC] = 1'b1;
        enable[EN_MAR]     = 1'b1;
        pc_inc             = 1'b1;
      end
      S_T1: begin
        busy           = 1'b1;
        mem_read       = 1'b1;
        enable[EN_MDR] = 1'b1;
      end
      S_T2: begin
        busy                = 1'b1;
        bus_select[SRC_MDR] = 1'b1;
        enable[EN_IR]       = 1'b1;
      end
      S_T3: begin
        // Illegal opcodes leave the datapath untouched on their way out.
        busy = 1'b1;
        if (legal) begin
          bus_select[ra] = 1'b1;
          enable[EN_Y]   = 1'b1;
        end
      end
      S_T4: begin
        busy           = 1'b1;
        bus_select[rb] = 1'b1;
        alu_op         = OPCODE_W'(opcode);
        enable[EN_Z]   = 1'b1;
      end
      S_T5: begin
        busy                = 1'b1;
        bus_select[SRC_ZLO] = 1'b1;
        enable[EN_LO]       = 1'b1;
      end
      S_T6: begin
        busy                = 1'b1;
        bus_select[SRC_ZHI] = 1'b1;
        enable[EN_HI]       = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  logic unused_guard;
  assign unused_guard = state_t_unused_guard;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Control sequencer running one MUL (or, optionally, DIV) instruction
//   through the datapath: fetch (T0-T2), operand transfer and ALU (T3-T4),
//   LO/HI writeback (T5-T6), then a one-cycle DONE.
// Configuration macro: MULDIV_SEQ_DIV_EN (enables DIV as a legal opcode).
// Ports:
//   clk        in   clock, rising edge
//   clr        in   asynchronous active-low reset
//   start      in   begin one instruction (sampled only in IDLE)
//   mem_ready  in   memory data valid; T1 waits for it
//   ir         in   IR contents from the datapath (must be stable T3-T6)
//   enable     out  one-hot register load enables
//   bus_select out  one-hot bus source select
//   mem_read   out  MDR loads from memory data
//   pc_inc     out  PC increment
//   alu_op     out  ALU opcode
//   busy       out  sequence in progress (T0-T6)
//   done       out  one-cycle completion pulse
//   err        out  illegal opcode flag, valid with done, held until next start
//   state_dbg  out  current FSM state encoding for observation
// Handshake: start is a request accepted only in IDLE; starts in any other
// state (including DONE) are dropped, not queued. done is a single-cycle
// pulse with no back-pressure; err is meaningful whenever done is high.
module muldiv_sequencer
  import muldiv_seq_pkg::*;
#(
  parameter int ENABLE_W = 32,
  parameter int SELECT_W = 32,
  parameter int OPCODE_W = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic [ENABLE_W-1:0] enable,
  output logic [SELECT_W-1:0] bus_select,
  output logic                mem_read,
  output logic                pc_inc,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [3:0]          state_dbg
);

  state_t     state, state_nxt;
  logic [4:0] opcode;
  logic [3:0] ra, rb;
  logic       legal;

  assign opcode = ir[IR_OP_MSB:IR_OP_LSB];
  assign ra     = ir[IR_RA_MSB:IR_RA_LSB];
  assign rb     = ir[IR_RB_MSB:IR_RB_LSB];
  assign legal  = op_is_legal(opcode);

  // Low IR bits carry immediates this sequencer never uses.
  logic unused_ir;
  assign unused_ir = ^ir[IR_RB_LSB-1:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        err <= 1'b0;
      end else if (state == S_T3 && !legal) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    if (mem_ready) state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = legal ? S_T4 : S_DONE;
      S_T4:    state_nxt = S_T5;
      S_T5:    state_nxt = S_T6;
      S_T6:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign state_dbg = state;

  muldiv_seq_decode #(
    .ENABLE_W(ENABLE_W),
    .SELECT_W(SELECT_W),
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .state_t_unused_guard(1'b0),
    .state               (state),
    .opcode              (opcode),
    .ra                  (ra),
    .rb                  (rb),
    .legal               (legal),
    .enable              (enable),
    .bus_select          (bus_select),
    .mem_read            (mem_read),
    .pc_inc              (pc_inc),
    .alu_op              (alu_op),
    .busy                (busy),
    .done                (done)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed bench for muldiv_sequencer. Inputs change and outputs are
//   sampled on the falling edge. Cycle c of a run is the c-th falling edge
//   after the one where start was raised, so T0 is cycle 1 and a full MUL
//   shows done in cycle 8.
module tb_muldiv_sequencer;

  logic        clk;
  logic        clr;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic [31:0] enable;
  logic [31:0] bus_select;
  logic        mem_read;
  logic        pc_inc;
  logic [4:0]  alu_op;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  localparam int MAXC = 40;

  // Per-cycle history of one run, filled by run_instr.
  logic [31:0] en_h  [0:MAXC];
  logic [31:0] sel_h [0:MAXC];
  logic [4:0]  op_h  [0:MAXC];
  logic        busy_h[0:MAXC];
  logic        pci_h [0:MAXC];
  logic        mrd_h [0:MAXC];
  logic        err_h [0:MAXC];
  int          done_cyc;
  int          done_count;
  logic        err_at_done;

  // Hand-computed one-hot constants.
  localparam logic [31:0] B_PC_SRC = 32'h0010_0000; // bit 20
  localparam logic [31:0] B_MAR    = 32'h0200_0000; // bit 25
  localparam logic [31:0] B_MDR    = 32'h0020_0000; // bit 21
  localparam logic [31:0] B_IR     = 32'h0040_0000; // bit 22
  localparam logic [31:0] B_Y      = 32'h0080_0000; // bit 23
  localparam logic [31:0] B_Z      = 32'h0004_0000; // bit 18
  localparam logic [31:0] B_ZHI    = 32'h0004_0000; // bit 18
  localparam logic [31:0] B_ZLO    = 32'h0008_0000; // bit 19
  localparam logic [31:0] B_LO     = 32'h0002_0000; // bit 17
  localparam logic [31:0] B_HI     = 32'h0001_0000; // bit 16
  localparam logic [31:0] B_R6     = 32'h0000_0040;
  localparam logic [31:0] B_R7     = 32'h0000_0080;
  localparam logic [31:0] WB_MASK  = 32'h0087_0000; // Y, Z, LO, HI

  localparam logic [31:0] IR_MUL   = 32'h7B38_0000; // MUL R6,R7
  localparam logic [31:0] IR_DIV   = 32'h8338_0000; // DIV R6,R7 (opcode 10000)
  localparam logic [31:0] IR_OP17  = 32'h8B38_0000; // opcode 10001, one past DIV
  localparam logic [31:0] IR_ZERO  = 32'h0000_0000; // opcode 00000

  muldiv_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .mem_ready (mem_ready),
    .ir        (ir),
    .enable    (enable),
    .bus_select(bus_select),
    .mem_read  (mem_read),
    .pc_inc    (pc_inc),
    .alu_op    (alu_op),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: raise start for one cycle with instruction ir_v, hold mem_ready
  // low for `stall` cycles of T1, and optionally pulse start again in
  // cycles p1/p2 (0 = none). Records outputs until 3 cycles past done.
  task automatic run_instr(input logic [31:0] ir_v, input int stall,
                           input int p1, input int p2);
    ir          = ir_v;
    done_cyc    = 0;
    done_count  = 0;
    err_at_done = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    mem_ready = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      start     = (c == p1) || (c == p2);
      mem_ready = !(c >= 2 && c <= stall + 1);
      en_h[c]   = enable;
      sel_h[c]  = bus_select;
      op_h[c]   = alu_op;
      busy_h[c] = busy;
      pci_h[c]  = pc_inc;
      mrd_h[c]  = mem_read;
      err_h[c]  = err;
      if (done) begin
        done_count++;
        if (done_cyc == 0) begin
          done_cyc    = c;
          err_at_done = err;
        end
      end
      if (done_cyc != 0 && c == done_cyc + 3) break;
    end
    start     = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; mem_ready = 1'b1; ir = '0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if ({enable, bus_select, mem_read, pc_inc, alu_op, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%h sel=%h busy=%b done=%b err=%b expected all 0",
               enable, bus_select, busy, done, err);
    end
  endtask

  task automatic test_mul();
    logic [31:0] exp_en [1:7];
    logic [31:0] exp_sel[1:7];
    exp_en  = '{B_MAR, B_MDR, B_IR, B_Y, B_Z, B_LO, B_HI};
    exp_sel = '{B_PC_SRC, 32'h0, B_MDR, B_R6, B_R7, B_ZLO, B_ZHI};
    run_instr(IR_MUL, 0, 0, 0);
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (en_h[c] !== exp_en[c] || sel_h[c] !== exp_sel[c] || busy_h[c] !== 1'b1) begin
        errors++;
        $display("FAIL mul_cycle%0d en=%h sel=%h busy=%b expected en=%h sel=%h busy=1",
                 c, en_h[c], sel_h[c], busy_h[c], exp_en[c], exp_sel[c]);
      end
    end
    checks++;
    if (pci_h[1] !== 1'b1 || mrd_h[2] !== 1'b1 || pci_h[2] !== 1'b0) begin
      errors++;
      $display("FAIL mul_fetch_strobes pc_inc(T0)=%b mem_read(T1)=%b pc_inc(T1)=%b expected 1 1 0",
               pci_h[1], mrd_h[2], pci_h[2]);
    end
    checks++;
    if (op_h[5] !== 5'b01111 || op_h[4] !== 5'b00000) begin
      errors++;
      $display("FAIL mul_alu_op T4=%b T3=%b expected 01111 00000", op_h[5], op_h[4]);
    end
    checks++;
    if (done_cyc !== 8 || err_at_done !== 1'b0 || done_count !== 1) begin
      errors++;
      $display("FAIL mul_done cycle=%0d err=%b count=%0d expected 8 0 1",
               done_cyc, err_at_done, done_count);
    end
  endtask

  task automatic test_stall();
    int t1_cycles;
    run_instr(IR_MUL, 3, 0, 0);
    t1_cycles = 0;
    for (int c = 1; c <= MAXC; c++) if (mrd_h[c] === 1'b1 && c <= done_cyc) t1_cycles++;
    checks++;
    if (t1_cycles !== 4) begin
      errors++;
      $display("FAIL stall_t1_len got %0d expected 4", t1_cycles);
    end
    checks++;
    if (done_cyc !== 11 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL stall_done cycle=%0d err=%b expected 11 0", done_cyc, err_at_done);
    end
    checks++;
    if (en_h[6] !== B_IR || en_h[9] !== B_LO) begin
      errors++;
      $display("FAIL stall_shift en(c6)=%h en(c9)=%h expected %h %h", en_h[6], en_h[9], B_IR, B_LO);
    end
  endtask

  task automatic test_div();
    logic [31:0] wb_seen;
    run_instr(IR_DIV, 0, 0, 0);
    wb_seen = '0;
    for (int c = 1; c <= MAXC; c++) if (c <= done_cyc) wb_seen |= en_h[c];
`ifdef MULDIV_SEQ_DIV_EN
    checks++;
    if (op_h[5] !== 5'b10000 || en_h[5] !== B_Z) begin
      errors++;
      $display("FAIL div_t4 alu_op=%b en=%h expected 10000 %h", op_h[5], en_h[5], B_Z);
    end
    checks++;
    if (done_cyc !== 8 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL div_done cycle=%0d err=%b expected 8 0", done_cyc, err_at_done);
    end
`else
    checks++;
    if (done_cyc !== 5 || err_at_done !== 1'b1) begin
      errors++;
      $display("FAIL div_illegal_done cycle=%0d err=%b expected 5 1", done_cyc, err_at_done);
    end
    checks++;
    if ((wb_seen & WB_MASK) !== 32'h0) begin
      errors++;
      $display("FAIL div_no_writeback enables=%h expected no Y/Z/LO/HI", wb_seen & WB_MASK);
    end
`endif
    // Opcode 10001 is illegal in every build.
    run_instr(IR_OP17, 0, 0, 0);
    checks++;
    if (done_cyc !== 5 || err_at_done !== 1'b1) begin
      errors++;
      $display("FAIL op10001_illegal cycle=%0d err=%b expected 5 1", done_cyc, err_at_done);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] wb_seen;
    run_instr(IR_ZERO, 0, 0, 0);
    wb_seen = '0;
    for (int c = 1; c <= MAXC; c++) if (c <= done_cyc) wb_seen |= en_h[c];
    checks++;
    if (done_cyc !== 5 || err_at_done !== 1'b1) begin
      errors++;
      $display("FAIL illegal_done cycle=%0d err=%b expected 5 1", done_cyc, err_at_done);
    end
    checks++;
    if (en_h[4] !== 32'h0 || sel_h[4] !== 32'h0 || (wb_seen & WB_MASK) !== 32'h0) begin
      errors++;
      $display("FAIL illegal_t3_quiet en=%h sel=%h wb=%h expected 0 0 0",
               en_h[4], sel_h[4], wb_seen & WB_MASK);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err_hold err=%b busy=%b expected 1 0", err, busy);
    end
    run_instr(IR_MUL, 0, 0, 0);
    checks++;
    if (err_h[1] !== 1'b0 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_start err(T0)=%b err(done)=%b expected 0 0",
               err_h[1], err_at_done);
    end
  endtask

  task automatic test_ignored_start();
    run_instr(IR_MUL, 0, 3, 8);
    checks++;
    if (done_count !== 1 || done_cyc !== 8) begin
      errors++;
      $display("FAIL ignored_start done_count=%0d done_cycle=%0d expected 1 8", done_count, done_cyc);
    end
    checks++;
    if (busy_h[9] !== 1'b0 || busy_h[10] !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_dropped busy(c9)=%b busy(c10)=%b expected 0 0",
               busy_h[9], busy_h[10]);
    end
  endtask

  task automatic test_reset_mid();
    int late_done;
    run_instr(IR_ZERO, 0, 0, 0);
    // Asynchronous clear while idle with err set.
    #2 clr = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_err err=%b expected 0", err);
    end
    @(negedge clk);
    clr = 1'b1;
    // Start MUL and clear mid-T4 (cycle 5).
    ir = IR_MUL;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (alu_op !== 5'b01111 || enable !== B_Z) begin
      errors++;
      $display("FAIL reset_mid_reach_t4 alu_op=%b en=%h expected 01111 %h", alu_op, enable, B_Z);
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if ({enable, bus_select, mem_read, pc_inc, alu_op, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async en=%h sel=%h alu_op=%b busy=%b expected all 0",
               enable, bus_select, alu_op, busy);
    end
    @(negedge clk);
    clr = 1'b1;
    late_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy || enable != 32'h0) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      errors++;
      $display("FAIL reset_mid_idle active_cycles=%0d expected 0", late_done);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_stall();
    test_div();
    test_illegal();
    test_ignored_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
